// File: rtl/collision_probe_pkg.sv
// collision_probe_pkg
// Shared level/screen constants, tile codes and the probe FSM encoding used by
// collision_probe and its corner-address sub-module.
// No ports (package).
package collision_probe_pkg;

    // Coordinate width of the screen/level address space.
    localparam int unsigned COORD_W = 10;

    // Playfield origin in screen pixels and the last valid tile row/column.
    localparam int unsigned TOP     = 35;
    localparam int unsigned LEFT    = 144;
    localparam int unsigned ROW_MAX = 29;
    localparam int unsigned COL_MAX = 19;

    // Tile codes returned by the level lookup port.
    localparam logic [2:0] TILE_EMPTY = 3'd0;
    localparam logic [2:0] TILE_OOB   = 3'd3;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StTl   = 3'd1,
        StTr   = 3'd2,
        StBl   = 3'd3,
        StBr   = 3'd4,
        StDone = 3'd5
    } probe_state_e;

    // A tile code is solid when its bit is set in the solid mask.
    function automatic logic tile_is_solid(input logic [7:0] mask, input logic [2:0] code);
        return mask[code];
    endfunction

endpackage

// File: rtl/probe_addr.sv
// probe_addr
// Corner-address mux: selects which hitbox corner to present to the level
// lookup port for a given probe state. Purely combinational.
// Ports:
//   i_state   state the address is being prepared for
//   i_base_x  hitbox top-left x
//   i_base_y  hitbox top-left y
//   o_addr_x  level lookup x (0 outside corner states)
//   o_addr_y  level lookup y (0 outside corner states)
module probe_addr
    import collision_probe_pkg::*;
#(
    parameter int unsigned HIT_W = 32,
    parameter int unsigned HIT_H = 32
) (
    input  probe_state_e       i_state,
    input  logic [COORD_W-1:0] i_base_x,
    input  logic [COORD_W-1:0] i_base_y,
    output logic [COORD_W-1:0] o_addr_x,
    output logic [COORD_W-1:0] o_addr_y
);

    // Offsets truncated to the coordinate width; sums wrap modulo 1024 and
    // any wrapped address is rejected by the level port's bounds check.
    localparam logic [COORD_W-1:0] OFF_X = COORD_W'(HIT_W - 1);
    localparam logic [COORD_W-1:0] OFF_Y = COORD_W'(HIT_H - 1);

    logic [COORD_W-1:0] w_right_x;
    logic [COORD_W-1:0] w_bottom_y;

    assign w_right_x  = i_base_x + OFF_X;
    assign w_bottom_y = i_base_y + OFF_Y;

    always_comb begin
        o_addr_x = '0;
        o_addr_y = '0;
        case (i_state)
            StTl: begin
                o_addr_x = i_base_x;
                o_addr_y = i_base_y;
            end
            StTr: begin
                o_addr_x = w_right_x;
                o_addr_y = i_base_y;
            end
            StBl: begin
                o_addr_x = i_base_x;
                o_addr_y = w_bottom_y;
            end
            StBr: begin
                o_addr_x = w_right_x;
                o_addr_y = w_bottom_y;
            end
            default: begin
                o_addr_x = '0;
                o_addr_y = '0;
            end
        endcase
    end

endmodule

// File: rtl/collision_probe.sv
// collision_probe
// Probes the four corners of a hitbox against a shared level lookup port and
// reports which corners land on solid tiles. One probe takes a fixed six
// cycles (IDLE accept, TL, TR, BL, BR, DONE); results and the done pulse appear
// together in the cycle after DONE.
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     probe request, honoured only in IDLE
//   px, py    candidate hitbox top-left (latched on accept)
//   lvl_x/y   registered address to the level lookup port
//   lvl_data  tile code for lvl_x/lvl_y (combinational return)
//   busy      probe in progress (TL..DONE)
//   done      one-cycle pulse when hits/blocked update
//   hits      per-corner solid flags {BR, BL, TR, TL}
//   blocked   OR of hits
module collision_probe
    import collision_probe_pkg::*;
#(
    parameter int unsigned HIT_W      = 32,
    parameter int unsigned HIT_H      = 32,
    parameter logic [7:0]  SOLID_MASK = 8'b1111_1110
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic [COORD_W-1:0] lvl_x,
    output logic [COORD_W-1:0] lvl_y,
    input  logic [2:0]         lvl_data,
    output logic               busy,
    output logic               done,
    output logic [3:0]         hits,
    output logic               blocked
);

    probe_state_e       r_state;
    probe_state_e       w_state_next;
    logic [COORD_W-1:0] r_base_x;
    logic [COORD_W-1:0] r_base_y;
    logic [COORD_W-1:0] r_lvl_x;
    logic [COORD_W-1:0] r_lvl_y;
    logic [3:0]         r_scratch;
    logic [3:0]         r_hits;
    logic               r_blocked;
    logic               r_done;

    logic               w_accept;
    logic               w_solid;
    logic [COORD_W-1:0] w_base_x;
    logic [COORD_W-1:0] w_base_y;
    logic [COORD_W-1:0] w_addr_x;
    logic [COORD_W-1:0] w_addr_y;

    assign w_accept = (r_state == StIdle) && start;
    assign w_solid  = tile_is_solid(SOLID_MASK, lvl_data);

    // The TL address is registered on the accept edge itself, so it must come
    // straight from px/py rather than the base registers being loaded alongside.
    assign w_base_x = w_accept ? px : r_base_x;
    assign w_base_y = w_accept ? py : r_base_y;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  w_state_next = start ? StTl : StIdle;
            StTl:    w_state_next = StTr;
            StTr:    w_state_next = StBl;
            StBl:    w_state_next = StBr;
            StBr:    w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Address for the state about to be entered, registered so lvl_x/lvl_y
    // are stable for the whole corner cycle.
    probe_addr #(
        .HIT_W (HIT_W),
        .HIT_H (HIT_H)
    ) u_probe_addr (
        .i_state  (w_state_next),
        .i_base_x (w_base_x),
        .i_base_y (w_base_y),
        .o_addr_x (w_addr_x),
        .o_addr_y (w_addr_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_base_x  <= '0;
            r_base_y  <= '0;
            r_lvl_x   <= '0;
            r_lvl_y   <= '0;
            r_scratch <= '0;
            r_hits    <= '0;
            r_blocked <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_lvl_x <= w_addr_x;
            r_lvl_y <= w_addr_y;
            r_done  <= (r_state == StDone);
            if (w_accept) begin
                r_base_x <= px;
                r_base_y <= py;
            end
            case (r_state)
                StTl: r_scratch[0] <= w_solid;
                StTr: r_scratch[1] <= w_solid;
                StBl: r_scratch[2] <= w_solid;
                StBr: r_scratch[3] <= w_solid;
                StDone: begin
                    r_hits    <= r_scratch;
                    r_blocked <= |r_scratch;
                end
                default: ;
            endcase
        end
    end

    assign lvl_x   = r_lvl_x;
    assign lvl_y   = r_lvl_y;
    assign busy    = (r_state != StIdle);
    assign done    = r_done;
    assign hits    = r_hits;
    assign blocked = r_blocked;

endmodule

// File: tb/tb_collision_probe.sv
// tb_collision_probe
// Directed bench for collision_probe. A behavioural level model (32x16 pixel
// tiles, playfield at x>=144, y>=35, 20x30 tiles, code 3 outside) answers the
// lookup port of the default-mask DUT; a second DUT with only code 3 solid sees
// a uniform tile code chosen by the bench.
module tb_collision_probe;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] px;
    logic [9:0] py;

    logic [9:0] lvl_x,  lvl_y,  lvl_x2, lvl_y2;
    logic [2:0] lvl_data;
    logic [2:0] code2;
    logic       busy,  done,  blocked;
    logic       busy2, done2, blocked2;
    logic [3:0] hits,  hits2;

    logic [2:0] tile_map [0:29][0:19];
    int         col;
    int         row;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    collision_probe u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .px       (px),
        .py       (py),
        .lvl_x    (lvl_x),
        .lvl_y    (lvl_y),
        .lvl_data (lvl_data),
        .busy     (busy),
        .done     (done),
        .hits     (hits),
        .blocked  (blocked)
    );

    collision_probe #(
        .SOLID_MASK (8'b0000_1000)
    ) u_dut_mask (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .px       (px),
        .py       (py),
        .lvl_x    (lvl_x2),
        .lvl_y    (lvl_y2),
        .lvl_data (code2),
        .busy     (busy2),
        .done     (done2),
        .hits     (hits2),
        .blocked  (blocked2)
    );

    // Level model: out of bounds returns code 3.
    always_comb begin
        lvl_data = 3'd3;
        col      = 0;
        row      = 0;
        if (lvl_x >= 10'd144 && lvl_y >= 10'd35) begin
            col = (int'(lvl_x) - 144) >> 5;
            row = (int'(lvl_y) - 35) >> 4;
            if (col <= 19 && row <= 29) lvl_data = tile_map[row][col];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse and wait (bounded) for done; returns in the done cycle.
    task automatic run_probe(input logic [9:0] x, input logic [9:0] y);
        bit seen;
        seen  = 1'b0;
        px    = x;
        py    = y;
        start = 1'b1;
        step();
        start = 1'b0;
        px    = 10'h3ff;
        py    = 10'h3ff;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (done) seen = 1'b1;
        end
        check_eq("probe_done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] done_mask;
        int          accepts;
        int          dones;

        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 20; c++)
                tile_map[r][c] = 3'd0;
        code2 = 3'd0;
        rst   = 1'b1;
        start = 1'b0;
        px    = '0;
        py    = '0;
        step();
        step();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_hits", 32'(hits), 32'd0);
        check_eq("rst_blocked", 32'(blocked), 32'd0);
        check_eq("rst_lvl", {6'd0, lvl_x, 6'd0, lvl_y}, 32'd0);
        rst = 1'b0;
        step();

        // Empty level: exact address sequence and latency; px/py scrambled after accept.
        px    = 10'd144;
        py    = 10'd35;
        start = 1'b1;
        step();
        start = 1'b0;
        px    = 10'd500;
        py    = 10'd400;
        check_eq("tl_busy", 32'(busy), 32'd1);
        check_eq("tl_addr", {6'd0, lvl_x, 6'd0, lvl_y}, {6'd0, 10'd144, 6'd0, 10'd35});
        step();
        check_eq("tr_addr", {6'd0, lvl_x, 6'd0, lvl_y}, {6'd0, 10'd175, 6'd0, 10'd35});
        step();
        check_eq("bl_addr", {6'd0, lvl_x, 6'd0, lvl_y}, {6'd0, 10'd144, 6'd0, 10'd66});
        step();
        check_eq("br_addr", {6'd0, lvl_x, 6'd0, lvl_y}, {6'd0, 10'd175, 6'd0, 10'd66});
        step();
        check_eq("done_state_addr", {6'd0, lvl_x, 6'd0, lvl_y}, 32'd0);
        check_eq("done_state_busy", 32'(busy), 32'd1);
        check_eq("done_early", 32'(done), 32'd0);
        step();
        check_eq("done_lat5", 32'(done), 32'd1);
        check_eq("done_idle", 32'(busy), 32'd0);
        check_eq("empty_hits", 32'(hits), 32'd0);
        check_eq("empty_blocked", 32'(blocked), 32'd0);
        step();
        check_eq("done_one_cycle", 32'(done), 32'd0);

        // Solid tile at row 0 col 1: only TR (191,35) lands on it; BR (191,66) is row 1.
        tile_map[0][1] = 3'd1;
        run_probe(10'd160, 10'd35);
        check_eq("tr_hits", 32'(hits), 32'b0010);
        check_eq("tr_blocked", 32'(blocked), 32'd1);
        step();

        // Reset during TR, with start also high to show reset wins.
        px    = 10'd144;
        py    = 10'd35;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_eq("mid_tr_addr", 32'(lvl_x), 32'd175);
        check_eq("mid_hits_held", 32'(hits), 32'b0010);
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_hits", 32'(hits), 32'd0);
        check_eq("abort_blocked", 32'(blocked), 32'd0);
        check_eq("abort_lvl", {6'd0, lvl_x, 6'd0, lvl_y}, 32'd0);
        dones = 0;
        for (int i = 0; i < 7; i++) begin
            if (done) dones++;
            step();
        end
        check_eq("abort_no_done", 32'(dones), 32'd0);
        run_probe(10'd160, 10'd35);
        check_eq("after_abort_hits", 32'(hits), 32'b0010);
        step();

        // Left corners (x=130) fall left of the playfield, right corners (x=161) inside.
        run_probe(10'd130, 10'd35);
        check_eq("oob_left_hits", 32'(hits), 32'b0101);
        check_eq("oob_left_blocked", 32'(blocked), 32'd1);
        step();

        // Start held 12 cycles: accepts at cycles 0 and 6, done at cycles 6 and 12.
        done_mask = '0;
        accepts   = 0;
        for (int i = 0; i < 14; i++) begin
            start = (i < 12);
            if (done) done_mask[i] = 1'b1;
            if (start && !busy) accepts++;
            step();
        end
        start = 1'b0;
        check_eq("held_accepts", 32'(accepts), 32'd2);
        check_eq("held_done_cycles", 32'(done_mask), 32'h1040);

        // Mask with only code 3 solid.
        code2 = 3'd1;
        run_probe(10'd144, 10'd35);
        check_eq("mask_code1_hits", 32'(hits2), 32'b0000);
        check_eq("mask_code1_blocked", 32'(blocked2), 32'd0);
        step();
        code2 = 3'd3;
        run_probe(10'd144, 10'd35);
        check_eq("mask_code3_hits", 32'(hits2), 32'b1111);
        check_eq("mask_code3_blocked", 32'(blocked2), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
